// File: rtl/saes_round_engine.sv
// Iterative S-AES round engine: one round per clock, valid/ready on both sides.
// Define SAES_DECRYPT_EN to compile in the inverse cipher selected by `decrypt`.
module saes_round_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_in,
    input  logic [15:0] key0,
    input  logic [15:0] key1,
    input  logic [15:0] key2,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_e;

    state_e      fsm_q, fsm_d;
    logic [15:0] st_q, st_d;
    logic [15:0] k1_q, k1_d;
    logic [15:0] k2_q, k2_d;
    logic [15:0] out_q, out_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h9_4_A_B_D_1_8_5_6_2_0_3_C_E_F_7;
        return t[60 - 4 * x +: 4];
    endfunction

    function automatic logic [15:0] sub(input logic [15:0] s);
        return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
    endfunction

    function automatic logic [15:0] sr(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [3:0] m2(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
    endfunction

    function automatic logic [3:0] m4(input logic [3:0] x);
        return m2(m2(x));
    endfunction

    function automatic logic [15:0] mc(input logic [15:0] s);
        return {s[15:12] ^ m4(s[11:8]), m4(s[15:12]) ^ s[11:8],
                s[7:4] ^ m4(s[3:0]),    m4(s[7:4]) ^ s[3:0]};
    endfunction

`ifdef SAES_DECRYPT_EN
    logic mode_q, mode_d;

    function automatic logic [3:0] isbox(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hA_5_9_B_1_7_8_F_6_0_2_3_C_4_D_E;
        return t[60 - 4 * x +: 4];
    endfunction

    function automatic logic [15:0] isub(input logic [15:0] s);
        return {isbox(s[15:12]), isbox(s[11:8]), isbox(s[7:4]), isbox(s[3:0])};
    endfunction

    function automatic logic [3:0] m9(input logic [3:0] x);
        return m2(m4(x)) ^ x;
    endfunction

    function automatic logic [15:0] imc(input logic [15:0] s);
        return {m9(s[15:12]) ^ m2(s[11:8]), m2(s[15:12]) ^ m9(s[11:8]),
                m9(s[7:4]) ^ m2(s[3:0]),    m2(s[7:4]) ^ m9(s[3:0])};
    endfunction
`else
    logic decrypt_unused;
    assign decrypt_unused = decrypt;
`endif

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        k1_d  = k1_q;
        k2_d  = k2_q;
        out_d = out_q;
`ifdef SAES_DECRYPT_EN
        mode_d = mode_q;
`endif
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    fsm_d = R1;
                    k1_d  = key1;
`ifdef SAES_DECRYPT_EN
                    // Decrypt parks key0 in the second slot for the final round
                    mode_d = decrypt;
                    k2_d   = decrypt ? key0 : key2;
                    st_d   = data_in ^ (decrypt ? key2 : key0);
`else
                    k2_d = key2;
                    st_d = data_in ^ key0;
`endif
                end
            end
            R1: begin
                fsm_d = R2;
                st_d  = mc(sr(sub(st_q))) ^ k1_q;
`ifdef SAES_DECRYPT_EN
                if (mode_q) st_d = imc(isub(sr(st_q)) ^ k1_q);
`endif
            end
            R2: begin
                fsm_d = DONE;
                out_d = sr(sub(st_q)) ^ k2_q;
                st_d  = out_d;
`ifdef SAES_DECRYPT_EN
                if (mode_q) begin
                    out_d = isub(sr(st_q)) ^ k2_q;
                    st_d  = st_q;
                end
`endif
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            k1_q  <= '0;
            k2_q  <= '0;
            out_q <= '0;
`ifdef SAES_DECRYPT_EN
            mode_q <= 1'b0;
`endif
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            k1_q  <= k1_d;
            k2_q  <= k2_d;
            out_q <= out_d;
`ifdef SAES_DECRYPT_EN
            mode_q <= mode_d;
`endif
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = (fsm_q == DONE);
    assign data_out  = out_q;

endmodule

// File: tb/tb_saes_round_engine.sv
// Directed bench for saes_round_engine with a result scoreboard.
// Expected ciphertexts come from a table/GF-multiply reference model.
module tb_saes_round_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data_in = '0;
    logic [15:0] key0 = '0;
    logic [15:0] key1 = '0;
    logic [15:0] key2 = '0;
    logic        decrypt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] data_out;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    logic [15:0] sbq[$];

    localparam logic [3:0] SB [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                       4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

    saes_round_engine dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key0(key0), .key1(key1), .key2(key2),
        .decrypt(decrypt),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;

    function automatic logic [3:0] gm(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] x;
        r = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = x[3] ? ((x << 1) ^ 4'h3) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] model_enc(input logic [15:0] p, input logic [15:0] k0,
                                              input logic [15:0] k1, input logic [15:0] k2);
        logic [3:0]  n[4];
        logic [3:0]  t[4];
        logic [15:0] s;
        s = p ^ k0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) n[i] = SB[s[15 - 4 * i -: 4]];
            t = n;
            n[1] = t[3];
            n[3] = t[1];
            if (r == 0) begin
                t = n;
                n[0] = t[0] ^ gm(4'h4, t[1]);
                n[1] = gm(4'h4, t[0]) ^ t[1];
                n[2] = t[2] ^ gm(4'h4, t[3]);
                n[3] = gm(4'h4, t[2]) ^ t[3];
            end
            s = {n[0], n[1], n[2], n[3]} ^ (r == 0 ? k1 : k2);
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [15:0] k0, input logic [15:0] k1,
                        input logic [15:0] k2, input logic dec, input logic [15:0] exp);
        int n;
        n = 0;
        data_in  = d;
        key0     = k0;
        key1     = k1;
        key2     = k2;
        decrypt  = dec;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("accept_ready", {15'd0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
        sbq.push_back(exp);
    endtask

    task automatic collect(input string tag);
        int n;
        logic [15:0] exp;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        if (out_valid) begin
            chk({tag, "_sb"}, {15'd0, sbq.size() != 0}, 16'd1);
            if (sbq.size() != 0) begin
                exp = sbq.pop_front();
                chk(tag, data_out, exp);
            end
            step();
        end
    endtask

    initial begin
        int h0;
        logic [15:0] d, a, b, c;

        #3 rst = 1'b1;
        #1;
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_data_out", data_out, 16'h0000);
        #10 rst = 1'b0;
        step();

        send(16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651, 1'b0, 16'h0738);
        chk("lat_busy_r1", {15'd0, busy}, 16'd1);
        chk("lat_ov_r1", {15'd0, out_valid}, 16'd0);
        step();
        chk("lat_ov_r2", {15'd0, out_valid}, 16'd0);
        step();
        chk("lat_ov_done", {15'd0, out_valid}, 16'd1);
        collect("enc_vec");
        chk("idle_after_hs", {15'd0, in_ready}, 16'd1);

        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            c = 16'($urandom);
            send(d, a, b, c, 1'b0, model_enc(d, a, b, c));
            collect("enc_rand");
        end

        out_ready = 1'b0;
        send(16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651, 1'b0, 16'h0738);
        for (int i = 0; i < 8 && !out_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {15'd0, out_valid}, 16'd1);
            chk("bp_hold_data", data_out, 16'h0738);
            step();
        end
        out_ready = 1'b1;
        collect("bp_result");
        chk("bp_idle_ready", {15'd0, in_ready}, 16'd1);
        chk("bp_idle_ov", {15'd0, out_valid}, 16'd0);

        h0 = hs_cnt;
        send(16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651, 1'b0, 16'h0738);
        in_valid = 1'b1;
        data_in  = 16'hFFFF;
        key0     = 16'h0000;
        key1     = 16'h0000;
        key2     = 16'h0000;
        chk("drop_in_ready", {15'd0, in_ready}, 16'd0);
        step();
        in_valid = 1'b0;
        collect("drop_result");
        for (int i = 0; i < 8; i++) step();
        chk("drop_one_completion", 16'(hs_cnt - h0), 16'd1);

        send(16'h1234, 16'hA73B, 16'h1C27, 16'h7651, 1'b0, 16'h0000);
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_ov", {15'd0, out_valid}, 16'd0);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_data", data_out, 16'h0000);
        #2 rst = 1'b0;
        sbq.delete();
        h0 = hs_cnt;
        for (int i = 0; i < 5; i++) step();
        chk("midrst_no_completion", 16'(hs_cnt - h0), 16'd0);
        chk("midrst_data_hold", data_out, 16'h0000);
        send(16'h6F6B, 16'hA73B, 16'h1C27, 16'h7651, 1'b0, 16'h0738);
        collect("midrst_fresh");

`ifdef SAES_DECRYPT_EN
        send(16'h0738, 16'hA73B, 16'h1C27, 16'h7651, 1'b1, 16'h6F6B);
`else
        send(16'h0738, 16'hA73B, 16'h1C27, 16'h7651, 1'b1,
             model_enc(16'h0738, 16'hA73B, 16'h1C27, 16'h7651));
`endif
        collect("decrypt_req");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
